axi_wr_traffic_gen: RTL and testbench
=====================================

Name: axi_wr_traffic_gen

Overview:
Parametrised AXI4 write traffic generator for DDR3 example-design bring-up and soak test. Supports two modes:
- full-memory sequential fill;
- single random-address bursts.

Data width is configurable. Multiple bursts may be outstanding. The W channel streams without gaps, and B responses are checked. Sits between the test sequencer and the DDR controller AXI write port, alongside the read checker that regenerates the same data pattern.

Parameters:
AXI_DW, 64, data width in bits; legal 64/128/256; DQ_LANES = AXI_DW/16
AXI_AW, 32, AXI address width
ID_W, 8, AXI ID width
MEM_SPACE_AW, 18, fill region size = 2^(MEM_SPACE_AW+2) bytes
FILL_LEN, 15, awlen used in fill mode
MAX_OUTSTANDING, 4, max AW accepted without B response; power of 2, 1..16
LFSR_SEED, 32'h1234_5678, PRBS seed, nonzero

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle command pulse; ignored while busy=1
mode  in  1  0 = sequential fill, 1 = single random burst
rand_addr  in  AXI_AW  byte address for mode 1
rand_id  in  ID_W  awid for mode 1
rand_len  in  8  awlen for mode 1
pattern_sel  in  2  0 address pattern, 1 alternating 0xFFFF/0x0000 lanes, 2 PRBS, 3 all-zero
busy  out  1  command in progress
done_p  out  1  one-cycle pulse when the last B of a command is received
bresp_err_cnt  out  16  count of B responses with bresp != OKAY; saturates at 0xFFFF
axi_awaddr/awid/awlen/awsize/awburst/awvalid  out  AXI_AW/ID_W/8/3/2/1  AW channel
axi_awready  in  1
axi_wdata/wstrb/wlast/wvalid  out  AXI_DW/AXI_DW/8/1/1  W channel
axi_wready  in  1
axi_bid/bresp/bvalid  in  ID_W/2/1
axi_bready  out  1  tied 1

Behaviour:
- Reset: all outputs 0 except axi_awsize = log2(AXI_DW/8) and axi_awburst = INCR (constant); bready = 1; wstrb all ones; LFSR = LFSR_SEED.
- AW FSM: IDLE -> ISSUE on start. ISSUE -> DRAIN after the last AW handshake. DRAIN -> IDLE when outstanding = 0 and the W FIFO is empty; done_p pulses that cycle.
- busy = (state != IDLE).
- Fill mode:
  - burst bytes BB = (FILL_LEN+1)*AXI_DW/8; awaddr starts at 0 and steps by BB per AW handshake.
  - Last burst is at 2^(MEM_SPACE_AW+2) - BB.
  - awid starts at 0, +1 per burst, wraps modulo 2^ID_W.
- Random mode: one burst.
  - awaddr = rand_addr with the low log2(AXI_DW/8) bits cleared.
  - awid = rand_id.
  - awlen = rand_len, clipped so the burst does not cross a 4 KB boundary: awlen = min(rand_len, (4096 - addr[11:0])/(AXI_DW/8) - 1).
  - All random-mode inputs are sampled at start.
- AW rules:
  - awvalid, once high, holds its payload until awready.
  - awvalid is not raised while outstanding = MAX_OUTSTANDING.
  - Back-to-back AW handshakes are allowed, one per cycle.
- outstanding counter: +1 on AW handshake, -1 on bvalid; both in the same cycle = no change.
- W engine:
  - AW handshake pushes {awaddr, awlen} into a MAX_OUTSTANDING-deep FIFO.
  - The W engine pops an entry and streams awlen+1 beats.
  - wvalid is held continuously while wready = 0: no bubbles, no dropping, data stable.
  - wlast is asserted on beat awlen; the next burst may start the cycle after wlast is accepted.
  - W is never issued ahead of its AW.
- Beat address = burst address + beat*(AXI_DW/8). Lane k (16 bits) data by pattern_sel:
  - 0: {b, b ^ (beat_addr[8:1] + k)}, where b = beat_addr[16:9].
  - 1: lane k = 0xFFFF for even k, 0x0000 for odd k.
  - 2: lane k = lfsr[15:0] ^ k; LFSR is x^31+x^28+1, steps once per accepted beat.
  - 3: zero.
- bresp_err_cnt increments on bvalid with bresp != 0; it is not cleared by start, only by reset.
- Reset mid-burst: everything returns to reset values immediately; no partial completion is reported.

Test Plan:
- AXI_DW=64, MEM_SPACE_AW=6, fill, awready/wready=1 -> 2 bursts at 0x000 and 0x080, awlen 15, 32 W beats, wlast on beats 15 and 31, done_p once, busy falls the next cycle.
- Random mode, rand_addr=0x0FC8, rand_len=15, AXI_DW=64 -> awaddr 0x0FC8, awlen clipped to 6, 7 beats, wlast on the 7th.
- wready toggled 1-0-1 per cycle, pattern 0 -> wdata/wlast stable while stalled; beat 0 lane0 = 0x0000, lane1 = 0x0001 for address 0.
- Bvalid withheld, MAX_OUTSTANDING=4, fill of 8 bursts -> exactly 4 AW handshakes, then awvalid held 0 until a B is returned.
- Two B responses with bresp=2'b10 -> bresp_err_cnt = 2; done_p still pulses.
- Assert rst_n low mid-burst, then start a new fill -> outputs return to reset values; the new fill starts at awaddr 0, awid 0.

Source files
------------

// File: rtl/axi_wr_traffic_gen.sv
// AXI4 write traffic generator: sequential memory fill or a single 4 KB-clipped random burst,
// with outstanding-AW limiting, a gapless W stream and B-response error counting.
module axi_wr_traffic_gen #(
    parameter int          AXI_DW          = 64,
    parameter int          AXI_AW          = 32,
    parameter int          ID_W            = 8,
    parameter int          MEM_SPACE_AW    = 18,
    parameter int          FILL_LEN        = 15,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] LFSR_SEED       = 32'h1234_5678
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    input  logic [AXI_AW-1:0]   rand_addr,
    input  logic [ID_W-1:0]     rand_id,
    input  logic [7:0]          rand_len,
    input  logic [1:0]          pattern_sel,
    output logic                busy,
    output logic                done_p,
    output logic [15:0]         bresp_err_cnt,
    output logic [AXI_AW-1:0]   axi_awaddr,
    output logic [ID_W-1:0]     axi_awid,
    output logic [7:0]          axi_awlen,
    output logic [2:0]          axi_awsize,
    output logic [1:0]          axi_awburst,
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [AXI_DW-1:0]   axi_wdata,
    output logic [AXI_DW/8-1:0] axi_wstrb,
    output logic                axi_wlast,
    output logic                axi_wvalid,
    input  logic                axi_wready,
    input  logic [ID_W-1:0]     axi_bid,
    input  logic [1:0]          axi_bresp,
    input  logic                axi_bvalid,
    output logic                axi_bready,
    output logic [1:0]          dbg_state_o
);
    localparam int BYTES = AXI_DW / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int LANES = AXI_DW / 16;
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam longint REGION = longint'(1) << (MEM_SPACE_AW + 2);
    localparam logic [AXI_AW-1:0] BB        = AXI_AW'((FILL_LEN + 1) * BYTES);
    localparam logic [AXI_AW-1:0] FILL_LAST = AXI_AW'(REGION - longint'((FILL_LEN + 1) * BYTES));
    localparam logic [CW-1:0]     MAXC      = CW'(MAX_OUTSTANDING);
    localparam logic [30:0]       SEED31    = (LFSR_SEED[30:0] == 31'd0) ? 31'd1 : LFSR_SEED[30:0];

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [1:0]          pat_q, pat_d;
    logic [AXI_AW-1:0]   aw_addr_q, aw_addr_d;
    logic [ID_W-1:0]     aw_id_q, aw_id_d;
    logic [7:0]          aw_len_q, aw_len_d;
    logic                awvalid_q, awvalid_d;
    logic [CW-1:0]       outst_q, outst_d, fcnt_q, fcnt_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                w_act_q, w_act_d;
    logic [AXI_AW-1:0]   w_addr_q, w_addr_d;
    logic [7:0]          w_beat_q, w_beat_d, w_len_q, w_len_d;
    logic [30:0]         lfsr_q, lfsr_d;
    logic [15:0]         err_q, err_d;
    logic [AXI_AW-1:0]   fa_q [MAX_OUTSTANDING];
    logic [7:0]          fl_q [MAX_OUTSTANDING];

    logic aw_hs, w_hs, w_last, b_dec, push, pop, aw_is_last;
    logic [AXI_AW-1:0] aligned;
    logic [12:0]       room_m1;
    logic [7:0]        clip_len;
    logic [15:0]       lane;
    logic [AXI_DW-1:0] wdata;
    logic              unused_bits;

    // Every channel transfers on the cycle where valid and ready are both high at the
    // rising edge; a raised valid keeps its payload unchanged until that transfer.
    assign aw_hs      = awvalid_q & axi_awready;
    assign w_hs       = w_act_q & axi_wready;
    assign w_last     = w_act_q & (w_beat_q == w_len_q);
    assign b_dec      = axi_bvalid & (outst_q != '0);
    assign push       = aw_hs;
    assign pop        = (fcnt_q != '0) & (~w_act_q | (w_hs & w_last));
    assign aw_is_last = mode_q | (aw_addr_q == FILL_LAST);

    // Random bursts are clipped so they end at or before the next 4 KB boundary.
    assign aligned  = {rand_addr[AXI_AW-1:SZ], {SZ{1'b0}}};
    assign room_m1  = ((13'd4096 - {1'b0, aligned[11:0]}) >> SZ) - 13'd1;
    assign clip_len = ({5'd0, rand_len} > room_m1) ? room_m1[7:0] : rand_len;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pat_d     = pat_q;
        aw_addr_d = aw_addr_q;
        aw_id_d   = aw_id_q;
        aw_len_d  = aw_len_q;
        awvalid_d = awvalid_q;
        outst_d   = outst_q;
        fcnt_d    = fcnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        w_act_d   = w_act_q;
        w_addr_d  = w_addr_q;
        w_beat_d  = w_beat_q;
        w_len_d   = w_len_q;
        lfsr_d    = lfsr_q;
        err_d     = err_q;
        done_p    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    mode_d  = mode;
                    pat_d   = pattern_sel;
                    if (mode) begin
                        aw_addr_d = aligned;
                        aw_id_d   = rand_id;
                        aw_len_d  = clip_len;
                    end else begin
                        aw_addr_d = '0;
                        aw_id_d   = '0;
                        aw_len_d  = 8'(FILL_LEN);
                    end
                end
            end
            S_ISSUE: begin
                if (aw_hs) begin
                    if (aw_is_last) begin
                        state_d = S_DRAIN;
                    end else begin
                        aw_addr_d = aw_addr_q + BB;
                        aw_id_d   = aw_id_q + ID_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if ((outst_q == '0) && (fcnt_q == '0) && !w_act_q) begin
                    state_d = S_IDLE;
                    done_p  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (aw_hs && !b_dec) outst_d = outst_q + CW'(1);
        else if (!aw_hs && b_dec) outst_d = outst_q - CW'(1);
        fcnt_d = fcnt_q + CW'(push) - CW'(pop);
        if (push) wr_ptr_d = ptr_next(wr_ptr_q);

        if (w_hs) begin
            lfsr_d = {lfsr_q[29:0], lfsr_q[30] ^ lfsr_q[27]};
            if (w_last) begin
                w_act_d = 1'b0;
            end else begin
                w_beat_d = w_beat_q + 8'd1;
                w_addr_d = w_addr_q + AXI_AW'(BYTES);
            end
        end
        // A queued burst starts right behind the accepted wlast, so W never bubbles.
        if (pop) begin
            w_act_d  = 1'b1;
            w_addr_d = fa_q[rd_ptr_q];
            w_len_d  = fl_q[rd_ptr_q];
            w_beat_d = 8'd0;
            rd_ptr_d = ptr_next(rd_ptr_q);
        end

        if (awvalid_q && !axi_awready) awvalid_d = 1'b1;
        else awvalid_d = (state_d == S_ISSUE) && (outst_d < MAXC) && (fcnt_d < MAXC);

        if (axi_bvalid && (axi_bresp != 2'b00) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            pat_q     <= 2'd0;
            aw_addr_q <= '0;
            aw_id_q   <= '0;
            aw_len_q  <= '0;
            awvalid_q <= 1'b0;
            outst_q   <= '0;
            fcnt_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            w_act_q   <= 1'b0;
            w_addr_q  <= '0;
            w_beat_q  <= '0;
            w_len_q   <= '0;
            lfsr_q    <= SEED31;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pat_q     <= pat_d;
            aw_addr_q <= aw_addr_d;
            aw_id_q   <= aw_id_d;
            aw_len_q  <= aw_len_d;
            awvalid_q <= awvalid_d;
            outst_q   <= outst_d;
            fcnt_q    <= fcnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            w_act_q   <= w_act_d;
            w_addr_q  <= w_addr_d;
            w_beat_q  <= w_beat_d;
            w_len_q   <= w_len_d;
            lfsr_q    <= lfsr_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fa_q[wr_ptr_q] <= aw_addr_q;
            fl_q[wr_ptr_q] <= aw_len_q;
        end
    end

    always_comb begin
        wdata = '0;
        lane  = '0;
        for (int k = 0; k < LANES; k++) begin
            case (pat_q)
                2'd0:    lane = {w_addr_q[16:9], w_addr_q[16:9] ^ (w_addr_q[8:1] + 8'(k))};
                2'd1:    lane = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
                2'd2:    lane = lfsr_q[15:0] ^ 16'(k);
                default: lane = 16'h0000;
            endcase
            wdata[16*k +: 16] = lane;
        end
        if (!w_act_q) wdata = '0;
    end

    assign busy          = (state_q != S_IDLE);
    assign bresp_err_cnt = err_q;
    assign axi_awaddr    = aw_addr_q;
    assign axi_awid      = aw_id_q;
    assign axi_awlen     = aw_len_q;
    assign axi_awsize    = 3'(SZ);
    assign axi_awburst   = 2'b01;
    assign axi_awvalid   = awvalid_q;
    assign axi_wdata     = wdata;
    assign axi_wstrb     = '1;
    assign axi_wlast     = w_last;
    assign axi_wvalid    = w_act_q;
    assign axi_bready    = 1'b1;
    assign dbg_state_o   = state_q;
    assign unused_bits   = ^{axi_bid, w_addr_q[AXI_AW-1:17], w_addr_q[0], rand_addr[SZ-1:0]};
endmodule

// File: tb/tb_axi_wr_traffic_gen.sv
// Directed bench for axi_wr_traffic_gen: fill, clipped random bursts, W stalls,
// outstanding limit with withheld B, error responses and reset mid-burst.
module tb_axi_wr_traffic_gen;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 8;
    localparam logic [30:0] SEED = 31'h1234_5678;

    logic          clk, rst_n, start, mode;
    logic [AW-1:0] rand_addr;
    logic [IW-1:0] rand_id;
    logic [7:0]    rand_len;
    logic [1:0]    pattern_sel;
    logic          busy, done_p;
    logic [15:0]   bresp_err_cnt;
    logic [AW-1:0] axi_awaddr;
    logic [IW-1:0] axi_awid;
    logic [7:0]    axi_awlen;
    logic [2:0]    axi_awsize;
    logic [1:0]    axi_awburst;
    logic          axi_awvalid, axi_awready;
    logic [DW-1:0] axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic          axi_wlast, axi_wvalid, axi_wready;
    logic [IW-1:0] axi_bid;
    logic [1:0]    axi_bresp;
    logic          axi_bvalid, axi_bready;
    logic [1:0]    dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0]   exp_q[$];
    logic [AW-1:0] aw_addr_log[$];
    logic [IW-1:0] aw_id_log[$];
    logic [7:0]    aw_len_log[$];
    logic [DW-1:0] w_data_log[$];
    logic          w_last_log[$];
    logic [15:0]   prbs_log[$];
    int done_cnt, pending_b, stall_checks, stall_viol, b_err_left;
    bit b_en, wr_toggle;

    axi_wr_traffic_gen #(
        .AXI_DW(DW), .AXI_AW(AW), .ID_W(IW), .MEM_SPACE_AW(8), .FILL_LEN(15),
        .MAX_OUTSTANDING(4), .LFSR_SEED(32'h1234_5678)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .rand_addr(rand_addr),
        .rand_id(rand_id), .rand_len(rand_len), .pattern_sel(pattern_sel), .busy(busy),
        .done_p(done_p), .bresp_err_cnt(bresp_err_cnt), .axi_awaddr(axi_awaddr),
        .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bid(axi_bid),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .dbg_state_o(dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Monitor: samples on the falling edge, logs handshakes and checks W stability under stall
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic [30:0]   lfsr_m;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        lfsr_m     = SEED;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                lfsr_m     = SEED;
            end else begin
                if (prev_stall) begin
                    stall_checks++;
                    if (!(axi_wvalid === 1'b1 && axi_wdata === prev_data && axi_wlast === prev_last))
                        stall_viol++;
                end
                prev_stall = axi_wvalid && !axi_wready;
                prev_data  = axi_wdata;
                prev_last  = axi_wlast;
                if (axi_awvalid && axi_awready) begin
                    aw_addr_log.push_back(axi_awaddr);
                    aw_id_log.push_back(axi_awid);
                    aw_len_log.push_back(axi_awlen);
                end
                if (axi_wvalid && axi_wready) begin
                    w_data_log.push_back(axi_wdata);
                    w_last_log.push_back(axi_wlast);
                    prbs_log.push_back(lfsr_m[15:0]);
                    lfsr_m = {lfsr_m[29:0], lfsr_m[30] ^ lfsr_m[27]};
                    if (axi_wlast) pending_b++;
                end
                if (done_p) done_cnt++;
            end
        end
    end

    // Slave driver: one B per completed burst when enabled, optional wready toggling
    initial begin
        axi_bvalid = 1'b0;
        axi_bresp  = 2'b00;
        axi_bid    = '0;
        axi_wready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                axi_bvalid = 1'b0;
                pending_b  = 0;
            end else if (b_en && pending_b > 0) begin
                axi_bvalid = 1'b1;
                axi_bresp  = (b_err_left > 0) ? 2'b10 : 2'b00;
                if (b_err_left > 0) b_err_left--;
                pending_b--;
            end else begin
                axi_bvalid = 1'b0;
            end
            axi_wready = wr_toggle ? ~axi_wready : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clear_logs();
        exp_q.delete();
        aw_addr_log.delete();
        aw_id_log.delete();
        aw_len_log.delete();
        w_data_log.delete();
        w_last_log.delete();
        prbs_log.delete();
        done_cnt     = 0;
        stall_checks = 0;
        stall_viol   = 0;
    endtask

    task automatic pulse_start(input logic m, input logic [AW-1:0] a, input logic [IW-1:0] id,
                               input logic [7:0] len, input logic [1:0] pat);
        @(posedge clk);
        #1;
        mode = m; rand_addr = a; rand_id = id; rand_len = len; pattern_sel = pat;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (done_p === 1'b1) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
        check({tag, "_busy_after_done"}, 64'(busy), 64'd0);
    endtask

    function automatic int count_lasts();
        int c = 0;
        foreach (w_last_log[i]) if (w_last_log[i]) c++;
        return c;
    endfunction

    initial begin
        int didx[4];
        int n;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; rand_addr = '0; rand_id = '0;
        rand_len = '0; pattern_sel = '0; axi_awready = 1'b1;
        b_en = 1'b1; wr_toggle = 1'b0; b_err_left = 0; pending_b = 0;
        clear_logs();

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_awvalid", 64'(axi_awvalid), 64'd0);
        check("rst_awsize", 64'(axi_awsize), 64'd3);
        check("rst_awburst", 64'(axi_awburst), 64'd1);
        check("rst_bready", 64'(axi_bready), 64'd1);
        check("rst_wstrb", 64'(axi_wstrb), 64'hFF);
        check("rst_wvalid", 64'(axi_wvalid), 64'd0);
        check("rst_wdata", 64'(axi_wdata), 64'd0);
        check("rst_errcnt", 64'(bresp_err_cnt), 64'd0);
        check("rst_done", 64'(done_p), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Fill, pattern 0; a start pulse while busy is ignored
        clear_logs();
        pulse_start(1'b0, '0, '0, 8'd0, 2'd0);
        repeat (5) @(posedge clk);
        pulse_start(1'b1, 32'h0000_0500, 8'h11, 8'd2, 2'd1);
        wait_done("fill", 3000);
        check("fill_aw_count", 64'(aw_addr_log.size()), 64'd8);
        check("fill_addr0", 64'(aw_addr_log[0]), 64'h000);
        check("fill_addr1", 64'(aw_addr_log[1]), 64'h080);
        check("fill_addr7", 64'(aw_addr_log[7]), 64'h380);
        check("fill_id1", 64'(aw_id_log[1]), 64'd1);
        check("fill_id7", 64'(aw_id_log[7]), 64'd7);
        check("fill_len0", 64'(aw_len_log[0]), 64'd15);
        check("fill_len7", 64'(aw_len_log[7]), 64'd15);
        check("fill_beats", 64'(w_data_log.size()), 64'd128);
        check("fill_wlast14", 64'(w_last_log[14]), 64'd0);
        check("fill_wlast15", 64'(w_last_log[15]), 64'd1);
        check("fill_wlast31", 64'(w_last_log[31]), 64'd1);
        check("fill_wlast_count", 64'(count_lasts()), 64'd8);
        check("fill_done_count", 64'(done_cnt), 64'd1);
        didx = '{0, 1, 64, 127};
        exp_q.push_back(64'h0003_0002_0001_0000);
        exp_q.push_back(64'h0007_0006_0005_0004);
        exp_q.push_back(64'h0102_0103_0100_0101);
        exp_q.push_back(64'h01FE_01FF_01FC_01FD);
        foreach (didx[i]) check($sformatf("fill_data_beat%0d", didx[i]), w_data_log[didx[i]], exp_q[i]);

        // Random burst clipped at the 4 KB boundary, unaligned address, pattern 1
        clear_logs();
        pulse_start(1'b1, 32'h0000_0FCD, 8'hA5, 8'd15, 2'd1);
        wait_done("rnd_clip", 500);
        check("rnd_clip_aw_count", 64'(aw_addr_log.size()), 64'd1);
        check("rnd_clip_addr", 64'(aw_addr_log[0]), 64'h0FC8);
        check("rnd_clip_id", 64'(aw_id_log[0]), 64'hA5);
        check("rnd_clip_len", 64'(aw_len_log[0]), 64'd6);
        check("rnd_clip_beats", 64'(w_data_log.size()), 64'd7);
        check("rnd_clip_wlast6", 64'(w_last_log[6]), 64'd1);
        check("rnd_clip_wlast_count", 64'(count_lasts()), 64'd1);
        check("rnd_clip_data0", w_data_log[0], 64'h0000_FFFF_0000_FFFF);
        check("rnd_clip_data6", w_data_log[6], 64'h0000_FFFF_0000_FFFF);

        // Random burst that fits, PRBS pattern
        clear_logs();
        pulse_start(1'b1, 32'h0000_1000, 8'h3C, 8'd3, 2'd2);
        wait_done("rnd_prbs", 500);
        check("rnd_prbs_addr", 64'(aw_addr_log[0]), 64'h1000);
        check("rnd_prbs_len", 64'(aw_len_log[0]), 64'd3);
        check("rnd_prbs_beats", 64'(w_data_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({prbs_log[i] ^ 16'd3, prbs_log[i] ^ 16'd2, prbs_log[i] ^ 16'd1, prbs_log[i]});
            check($sformatf("rnd_prbs_data%0d", i), w_data_log[i], exp_q[i]);
        end

        // wready toggling every cycle, pattern 0 at address 0
        clear_logs();
        wr_toggle = 1'b1;
        pulse_start(1'b1, 32'h0000_0000, 8'h01, 8'd3, 2'd0);
        wait_done("stall", 500);
        wr_toggle = 1'b0;
        check("stall_seen", 64'(stall_checks > 0), 64'd1);
        check("stall_violations", 64'(stall_viol), 64'd0);
        check("stall_beats", 64'(w_data_log.size()), 64'd4);
        check("stall_data0", w_data_log[0], 64'h0003_0002_0001_0000);
        check("stall_data3", w_data_log[3], 64'h000F_000E_000D_000C);
        check("stall_wlast2", 64'(w_last_log[2]), 64'd0);
        check("stall_wlast3", 64'(w_last_log[3]), 64'd1);

        // B withheld: outstanding limit of 4, then two error responses
        clear_logs();
        b_en = 1'b0;
        b_err_left = 2;
        pulse_start(1'b0, '0, '0, 8'd0, 2'd3);
        repeat (100) @(negedge clk);
        check("ost_aw_count", 64'(aw_addr_log.size()), 64'd4);
        check("ost_awvalid_low", 64'(axi_awvalid), 64'd0);
        check("ost_beats", 64'(w_data_log.size()), 64'd64);
        check("ost_busy", 64'(busy), 64'd1);
        b_en = 1'b1;
        n = 0;
        while (aw_addr_log.size() < 5 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("ost_resume", 64'(aw_addr_log.size() >= 5), 64'd1);
        wait_done("ost", 3000);
        check("ost_aw_total", 64'(aw_addr_log.size()), 64'd8);
        check("ost_id4", 64'(aw_id_log[4]), 64'd4);
        check("ost_beats_total", 64'(w_data_log.size()), 64'd128);
        check("ost_data127", w_data_log[127], 64'd0);
        check("ost_err_cnt", 64'(bresp_err_cnt), 64'd2);
        check("ost_done_count", 64'(done_cnt), 64'd1);

        // Reset in the middle of a fill, then a fresh fill
        clear_logs();
        pulse_start(1'b0, '0, '0, 8'd0, 2'd0);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_awvalid", 64'(axi_awvalid), 64'd0);
        check("mid_rst_awaddr", 64'(axi_awaddr), 64'd0);
        check("mid_rst_wvalid", 64'(axi_wvalid), 64'd0);
        check("mid_rst_wlast", 64'(axi_wlast), 64'd0);
        check("mid_rst_wdata", axi_wdata, 64'd0);
        check("mid_rst_errcnt", 64'(bresp_err_cnt), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        pulse_start(1'b0, '0, '0, 8'd0, 2'd0);
        wait_done("refill", 3000);
        check("refill_addr0", 64'(aw_addr_log[0]), 64'd0);
        check("refill_id0", 64'(aw_id_log[0]), 64'd0);
        check("refill_aw_count", 64'(aw_addr_log.size()), 64'd8);
        check("refill_done_count", 64'(done_cnt), 64'd1);
        check("refill_errcnt", 64'(bresp_err_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
